// File: rtl/sevseg_frame_decoder.sv
// rtl/sevseg_frame_decoder.sv - serial active-low 7-segment frame to packed BCD and binary
// Frames arrive MS digit first; a result is registered one cycle after the beat carrying seg_last.
module sevseg_frame_decoder #(
  parameter int DIGITS = 2,
  parameter int BW     = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            seg_in,
  input  logic                  seg_valid,
  input  logic                  seg_last,
  output logic [BW-1:0]         bin_out,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  out_valid,
  output logic                  err
);

  localparam int BCDW = 4 * DIGITS;

  typedef enum logic {IDLE, ACC} state_t;

  state_t          state, state_nxt;
  logic [BW-1:0]   acc_bin, acc_bin_nxt;
  logic [BCDW-1:0] acc_bcd, acc_bcd_nxt;
  logic [2:0]      cnt, cnt_nxt;
  logic            ferr, ferr_nxt;
  logic [3:0]      dig;
  logic            illegal;
  logic            room;

  // Blank display reads as zero; anything unrecognised also contributes zero but flags the frame.
  always_comb begin
    dig     = 4'd0;
    illegal = 1'b0;
    case (seg_in)
      7'b1000000, 7'b1111111: dig = 4'd0;
      7'b1111001:             dig = 4'd1;
      7'b0100100:             dig = 4'd2;
      7'b0110000:             dig = 4'd3;
      7'b0011001:             dig = 4'd4;
      7'b0010010:             dig = 4'd5;
      7'b0000010:             dig = 4'd6;
      7'b1111000:             dig = 4'd7;
      7'b0000000:             dig = 4'd8;
      7'b0010000:             dig = 4'd9;
      default:                illegal = 1'b1;
    endcase
  end

  always_comb begin
    state_nxt   = state;
    acc_bin_nxt = acc_bin;
    acc_bcd_nxt = acc_bcd;
    cnt_nxt     = cnt;
    ferr_nxt    = ferr;
    room        = (cnt < 3'(DIGITS));
    if (seg_valid) begin
      if (room) begin
        acc_bin_nxt = acc_bin * BW'(10) + BW'(dig);
        acc_bcd_nxt = (acc_bcd << 4) | BCDW'(dig);
        cnt_nxt     = cnt + 3'd1;
      end else begin
        ferr_nxt = 1'b1;
      end
      if (illegal) ferr_nxt = 1'b1;
      state_nxt = seg_last ? IDLE : ACC;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // The completion beat folds into the outputs and restarts the accumulators in the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_bin <= '0;
      acc_bcd <= '0;
      cnt     <= '0;
      ferr    <= 1'b0;
    end else if (seg_valid && seg_last) begin
      acc_bin <= '0;
      acc_bcd <= '0;
      cnt     <= '0;
      ferr    <= 1'b0;
    end else if (seg_valid) begin
      acc_bin <= acc_bin_nxt;
      acc_bcd <= acc_bcd_nxt;
      cnt     <= cnt_nxt;
      ferr    <= ferr_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_out   <= '0;
      bcd_out   <= '0;
      err       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= seg_valid && seg_last;
      if (seg_valid && seg_last) begin
        bin_out <= acc_bin_nxt;
        bcd_out <= acc_bcd_nxt;
        err     <= ferr_nxt;
      end
    end
  end

endmodule

// File: tb/tb_sevseg_frame_decoder.sv
// tb/tb_sevseg_frame_decoder.sv - directed frames checked against a digit-list model every cycle
module tb_sevseg_frame_decoder;

  localparam int DIGITS = 2;
  localparam int BW     = 7;

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                         S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                         S7 = 7'b1111000, S8 = 7'b0000000, S9 = 7'b0010000,
                         SBLANK = 7'b1111111, SBAD = 7'b0000001;

  logic                clk = 1'b0;
  logic                rst;
  logic [6:0]          seg_in;
  logic                seg_valid;
  logic                seg_last;
  logic [BW-1:0]       bin_out;
  logic [4*DIGITS-1:0] bcd_out;
  logic                out_valid;
  logic                err;

  int total = 0;
  int bad   = 0;

  sevseg_frame_decoder #(.DIGITS(DIGITS), .BW(BW)) dut (
    .clk       (clk),
    .rst       (rst),
    .seg_in    (seg_in),
    .seg_valid (seg_valid),
    .seg_last  (seg_last),
    .bin_out   (bin_out),
    .bcd_out   (bcd_out),
    .out_valid (out_valid),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Model: remember the frame as a list of digits (-1 = illegal), evaluate it when it ends.
  int frame[$];
  int exp_bin = 0;
  int exp_bcd = 0;
  bit exp_err = 1'b0;
  bit exp_ov  = 1'b0;

  function automatic int pattern_to_digit(input logic [6:0] p);
    logic [6:0] tbl [10];
    tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
            7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    if (p == 7'b1111111) return 0;
    for (int k = 0; k < 10; k++) if (tbl[k] == p) return k;
    return -1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      frame.delete();
      exp_bin = 0; exp_bcd = 0; exp_err = 1'b0; exp_ov = 1'b0;
    end else begin
      exp_ov = 1'b0;
      if (seg_valid) begin
        frame.push_back(pattern_to_digit(seg_in));
        if (seg_last) begin
          int v, b, d;
          bit e;
          v = 0; b = 0; e = (frame.size() > DIGITS);
          for (int k = 0; k < frame.size(); k++) begin
            if (frame[k] < 0) e = 1'b1;
            if (k < DIGITS) begin
              d = (frame[k] < 0) ? 0 : frame[k];
              v = v * 10 + d;
              b = b * 16 + d;
            end
          end
          exp_bin = v; exp_bcd = b; exp_err = e; exp_ov = 1'b1;
          frame.delete();
        end
      end
    end
  end

  always @(negedge clk) begin
    total += 4;
    if (out_valid !== exp_ov) begin
      bad++; $display("FAIL cyc_out_valid t=%0t got=%b exp=%b", $time, out_valid, exp_ov);
    end
    if (bin_out !== BW'(exp_bin)) begin
      bad++; $display("FAIL cyc_bin_out t=%0t got=%0d exp=%0d", $time, bin_out, exp_bin);
    end
    if (bcd_out !== (4*DIGITS)'(exp_bcd)) begin
      bad++; $display("FAIL cyc_bcd_out t=%0t got=%h exp=%h", $time, bcd_out, exp_bcd);
    end
    if (err !== exp_err) begin
      bad++; $display("FAIL cyc_err t=%0t got=%b exp=%b", $time, err, exp_err);
    end
  end

  task automatic beat(input logic [6:0] s, input logic l);
    seg_in = s; seg_valid = 1'b1; seg_last = l;
    @(negedge clk);
    seg_valid = 1'b0; seg_last = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_lit(input string name, input int b, input int bcd, input logic e, input logic ov);
    total++;
    if (bin_out !== BW'(b) || bcd_out !== (4*DIGITS)'(bcd) || err !== e || out_valid !== ov) begin
      bad++;
      $display("FAIL %s got bin=%0d bcd=%h err=%b ov=%b exp bin=%0d bcd=%h err=%b ov=%b",
               name, bin_out, bcd_out, err, out_valid, b, bcd, e, ov);
    end
  endtask

  initial begin
    rst = 1'b1; seg_in = 7'h7F; seg_valid = 1'b0; seg_last = 1'b0;
    idle(2);
    expect_lit("reset_state", 0, 8'h00, 1'b0, 1'b0);
    rst = 1'b0;
    idle(2);

    beat(S2, 1'b0); beat(S3, 1'b1);
    expect_lit("frame_23", 23, 8'h23, 1'b0, 1'b1);
    idle(1);
    expect_lit("hold_23", 23, 8'h23, 1'b0, 1'b0);

    beat(S7, 1'b1);
    expect_lit("single_7", 7, 8'h07, 1'b0, 1'b1);
    idle(1);
    expect_lit("single_7_pulse_end", 7, 8'h07, 1'b0, 1'b0);

    beat(S9, 1'b0); beat(SBAD, 1'b1);
    expect_lit("illegal_90", 90, 8'h90, 1'b1, 1'b1);
    idle(2);

    beat(S1, 1'b0); idle(3); beat(S2, 1'b0); beat(S3, 1'b1);
    expect_lit("overlen_12", 12, 8'h12, 1'b1, 1'b1);
    idle(1);

    beat(S5, 1'b0);
    #2 rst = 1'b1;
    @(negedge clk);
    expect_lit("mid_reset", 0, 8'h00, 1'b0, 1'b0);
    #2 rst = 1'b0;
    @(negedge clk);
    beat(S4, 1'b1);
    expect_lit("after_reset_4", 4, 8'h04, 1'b0, 1'b1);
    idle(1);

    beat(S9, 1'b0); beat(S9, 1'b1);
    expect_lit("b2b_99", 99, 8'h99, 1'b0, 1'b1);
    beat(S0, 1'b0); beat(S1, 1'b1);
    expect_lit("b2b_01", 1, 8'h01, 1'b0, 1'b1);
    beat(SBLANK, 1'b0); beat(S8, 1'b1);
    expect_lit("blank_08", 8, 8'h08, 1'b0, 1'b1);
    idle(1);
    expect_lit("final_hold", 8, 8'h08, 1'b0, 1'b0);

    seg_in = S5; seg_last = 1'b1;
    idle(2);
    seg_last = 1'b0;
    expect_lit("last_without_valid", 8, 8'h08, 1'b0, 1'b0);
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
